// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and memory.
//
//   o_ireq    fetch request valid          (fetch -> memory)
//   o_iaddr   fetch address, XLEN bits     (fetch -> memory)
//   i_igrant  memory accepts the request   (memory -> fetch)
//   i_ivalid  response valid, in order     (memory -> fetch)
//   i_idata   response word, XLEN bits     (memory -> fetch)
//
// A transfer happens in any cycle with o_ireq & i_igrant. Each transfer gets
// exactly one response, no earlier than the cycle after the transfer.
// ----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            o_ireq;
  logic [XLEN-1:0] o_iaddr;
  logic            i_igrant;
  logic            i_ivalid;
  logic [XLEN-1:0] i_idata;

  modport master (
    output o_ireq, o_iaddr,
    input  i_igrant, i_ivalid, i_idata
  );

  modport slave (
    input  o_ireq, o_iaddr,
    output i_igrant, i_ivalid, i_idata
  );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Sequential instruction prefetcher. Issues fetch requests over the memory
// bus, tags in-order responses with their PCs, and buffers them in a
// DEPTH-entry queue that presents one instruction per cycle to decode.
// A taken jump flushes the queue and discards responses still in flight.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   bus        instruction-memory bus (master side)
//   i_stall    decode not consuming the current instruction
//   i_jp_en    jump taken by the instruction on o_inst (acts on consume only)
//   i_jp_addr  jump target, bits [1:0] ignored
//   o_valid    o_inst / o_pc hold a valid instruction
//   o_inst     instruction at queue head
//   o_pc       PC of o_inst
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    bus,
  input  logic            i_stall,
  input  logic            i_jp_en,
  input  logic [XLEN-1:0] i_jp_addr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t            queue [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;   // valid entries in the queue
  logic [CNT_W-1:0]  outst;   // granted requests whose data will be kept
  logic [CNT_W-1:0]  drop;    // in-flight responses belonging to a flushed path
  logic [XLEN-1:0]   f_pc;    // next address to request
  logic [XLEN-1:0]   r_pc;    // PC of the next kept response

  logic [SUM_W-1:0]  credit_sum;
  logic              transfer;
  logic              consume;
  logic              flush;
  logic              resp_keep;
  logic              resp_drop;
  logic [XLEN-1:0]   jp_target;
  logic              unused_jp_low;

  // Every queue slot, every in-flight keep and every in-flight drop holds one
  // credit, so a kept response always finds a free slot.
  assign credit_sum  = SUM_W'(count) + SUM_W'(outst) + SUM_W'(drop);
  assign bus.o_ireq  = !rst && (credit_sum < SUM_W'(DEPTH));
  assign bus.o_iaddr = f_pc;

  assign transfer  = bus.o_ireq && bus.i_igrant;
  assign consume   = o_valid && !i_stall;
  assign flush     = consume && i_jp_en;
  assign resp_keep = bus.i_ivalid && (drop == '0);
  assign resp_drop = bus.i_ivalid && (drop != '0);
  assign jp_target = {i_jp_addr[XLEN-1:2], 2'b00};
  assign unused_jp_low = ^i_jp_addr[1:0];

  // Head of queue drives decode directly; no response-to-output bypass.
  assign o_valid = (count != '0);
  assign o_inst  = queue[head].inst;
  assign o_pc    = queue[head].pc;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc  <= RESET_PC;
      r_pc  <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      outst <= '0;
      drop  <= '0;
      // NOTE: the queue is a handful of flops, so it is reset to give the
      // head outputs a defined value (o_inst = 0, o_pc = RESET_PC); a large
      // RAM-backed buffer would leave its contents unreset.
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= '{pc: RESET_PC, inst: '0};
      end
    end else if (flush) begin
      f_pc  <= jp_target;
      r_pc  <= jp_target;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      outst <= '0;
      // Everything still in flight, including a request granted this cycle,
      // is now stale; a response arriving this cycle retires one of them.
      drop  <= drop + outst + CNT_W'(transfer) - CNT_W'(bus.i_ivalid);
    end else begin
      if (transfer) begin
        f_pc <= f_pc + XLEN'(4);
      end
      if (resp_keep) begin
        queue[tail] <= '{pc: r_pc, inst: bus.i_idata};
        tail        <= tail + 1'b1;
        r_pc        <= r_pc + XLEN'(4);
      end
      if (consume) begin
        head <= head + 1'b1;
      end
      if (resp_drop) begin
        drop <= drop - 1'b1;
      end
      count <= count + CNT_W'(resp_keep) - CNT_W'(consume);
      outst <= outst + CNT_W'(transfer) - CNT_W'(resp_keep);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit with a behavioural in-order memory (configurable grant
// probability and latency) and a decode model (stalls, jumps). Expected PCs,
// instruction words and request addresses come from a program-order model:
// the next PC is the previous plus 4, or the aligned target after a taken
// jump; the memory word at address a is a fixed hash of a.
// ----------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_stall;
  logic        i_jp_en;
  logic [31:0] i_jp_addr;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .i_stall   (i_stall),
    .i_jp_en   (i_jp_en),
    .i_jp_addr (i_jp_addr),
    .o_valid   (o_valid),
    .o_inst    (o_inst),
    .o_pc      (o_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model: in-order requests waiting for their response cycle.
  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mreq_t;
  mreq_t mq[$];
  int    cycle;
  int    last_ready;
  int    grant_pct;
  int    lat_min;
  int    lat_max;

  // Program-order reference model.
  logic [31:0] exp_pc;
  logic [31:0] exp_req;

  // Per-cycle observations filled in by step().
  logic        s_valid, s_cons, s_flush, s_xfer, s_resp;
  logic [31:0] s_pc, s_inst, s_iaddr, s_exp_pc, s_exp_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Holds rst high across one clock edge; leaves rst asserted.
  task automatic apply_reset();
    rst          = 1'b1;
    bus.i_igrant = 1'b0;
    bus.i_ivalid = 1'b0;
    bus.i_idata  = '0;
    i_stall      = 1'b0;
    i_jp_en      = 1'b0;
    i_jp_addr    = '0;
    @(negedge clk);
    mq.delete();
    cycle      = 0;
    last_ready = -1;
    exp_pc     = RPC;
    exp_req    = RPC;
  endtask

  // One clock cycle: drive memory, sample outputs, advance the models.
  task automatic step();
    int          lat;
    int          r;
    logic [31:0] tgt;
    bus.i_igrant = ($urandom_range(99) < 32'(grant_pct));
    if (mq.size() != 0 && mq[0].ready <= cycle) begin
      bus.i_ivalid = 1'b1;
      bus.i_idata  = mem_word(mq[0].addr);
    end else begin
      bus.i_ivalid = 1'b0;
      bus.i_idata  = $urandom;
    end
    #1;
    s_valid   = o_valid;
    s_pc      = o_pc;
    s_inst    = o_inst;
    s_cons    = o_valid && !i_stall;
    s_flush   = s_cons && i_jp_en;
    s_xfer    = bus.o_ireq && bus.i_igrant;
    s_iaddr   = bus.o_iaddr;
    s_resp    = bus.i_ivalid;
    s_exp_pc  = exp_pc;
    s_exp_req = exp_req;
    tgt       = {i_jp_addr[31:2], 2'b00};
    if (bus.i_ivalid) void'(mq.pop_front());
    if (s_xfer) begin
      lat = $urandom_range(lat_max, lat_min);
      r   = cycle + lat;
      if (r <= last_ready) r = last_ready + 1;
      mq.push_back('{addr: s_iaddr, ready: r});
      last_ready = r;
      exp_req    = exp_req + 32'd4;
    end
    if (s_cons) exp_pc = s_flush ? tgt : exp_pc + 32'd4;
    if (s_flush) exp_req = tgt;
    @(negedge clk);
    cycle++;
  endtask

  task automatic test_reset();
    grant_pct = 100; lat_min = 1; lat_max = 1;
    apply_reset();
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
    n_checks++; if (o_pc !== RPC) $display("FAIL reset_pc: got %h want %h", o_pc, RPC); else n_pass++;
    n_checks++; if (o_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", o_inst); else n_pass++;
    n_checks++; if (bus.o_ireq !== 1'b0) $display("FAIL reset_ireq: got %b want 0", bus.o_ireq); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.o_ireq !== 1'b1) $display("FAIL post_reset_ireq: got %b want 1", bus.o_ireq); else n_pass++;
    n_checks++; if (bus.o_iaddr !== RPC) $display("FAIL post_reset_iaddr: got %h want %h", bus.o_iaddr, RPC); else n_pass++;
  endtask

  task automatic test_latency();
    int first_valid = -1;
    int n_cons = 0;
    grant_pct = 100; lat_min = 1; lat_max = 1;
    apply_reset();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (s_valid && first_valid < 0) begin
        first_valid = c;
        n_checks++; if (s_pc !== RPC) $display("FAIL first_pc: got %h want %h", s_pc, RPC); else n_pass++;
      end
      if (s_xfer) begin
        n_checks++; if (s_iaddr !== s_exp_req) $display("FAIL lat_iaddr: got %h want %h", s_iaddr, s_exp_req); else n_pass++;
      end
      if (s_cons) begin
        n_cons++;
        n_checks++; if (s_pc !== s_exp_pc) $display("FAIL lat_pc: got %h want %h", s_pc, s_exp_pc); else n_pass++;
        n_checks++; if (s_inst !== mem_word(s_exp_pc)) $display("FAIL lat_inst: got %h want %h", s_inst, mem_word(s_exp_pc)); else n_pass++;
      end
    end
    n_checks++; if (first_valid != 2) $display("FAIL first_valid_cycle: got %0d want 2", first_valid); else n_pass++;
    n_checks++; if (n_cons != 18) $display("FAIL throughput: got %0d want 18", n_cons); else n_pass++;
  endtask

  task automatic test_stall_fill();
    int n_xfer = 0;
    int first_x = -1;
    logic [31:0] first_addr = '0;
    grant_pct = 100; lat_min = 1; lat_max = 1;
    apply_reset();
    rst = 1'b0;
    i_stall = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_xfer) n_xfer++;
    end
    n_checks++; if (n_xfer != DEPTH) $display("FAIL fill_xfers: got %0d want %0d", n_xfer, DEPTH); else n_pass++;
    n_checks++; if (bus.o_ireq !== 1'b0) $display("FAIL fill_ireq: got %b want 0", bus.o_ireq); else n_pass++;
    n_checks++; if (int'(dut.count) != DEPTH) $display("FAIL fill_count: got %0d want %0d", dut.count, DEPTH); else n_pass++;
    n_checks++; if (o_valid !== 1'b1) $display("FAIL fill_valid: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_pc !== RPC) $display("FAIL fill_pc: got %h want %h", o_pc, RPC); else n_pass++;
    i_stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_xfer && first_x < 0) begin
        first_x = k;
        first_addr = s_iaddr;
      end
      if (k < 4) begin
        n_checks++; if (s_cons !== 1'b1) $display("FAIL drain_pop%0d: got %b want 1", k, s_cons); else n_pass++;
        n_checks++; if (s_pc !== RPC + 32'(4 * k)) $display("FAIL drain_pc%0d: got %h want %h", k, s_pc, RPC + 32'(4 * k)); else n_pass++;
        n_checks++; if (s_inst !== mem_word(RPC + 32'(4 * k))) $display("FAIL drain_inst%0d: got %h want %h", k, s_inst, mem_word(RPC + 32'(4 * k))); else n_pass++;
      end
    end
    n_checks++; if (first_x < 0) $display("FAIL resume_req: got none want a request"); else n_pass++;
    n_checks++; if (first_addr !== RPC + 32'h10) $display("FAIL resume_addr: got %h want %h", first_addr, RPC + 32'h10); else n_pass++;
  endtask

  task automatic test_jump_lat3();
    logic done = 1'b0;
    logic seen = 1'b0;
    grant_pct = 100; lat_min = 3; lat_max = 3;
    apply_reset();
    rst = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (o_valid && o_pc == RPC + 32'h8) begin
        n_checks++; if (int'(dut.outst) != 2) $display("FAIL j3_outst: got %0d want 2", dut.outst); else n_pass++;
        i_jp_en = 1'b1; i_jp_addr = 32'h0000_0203;
        step();
        i_jp_en = 1'b0;
        n_checks++; if (s_flush !== 1'b1) $display("FAIL j3_flush: got %b want 1", s_flush); else n_pass++;
        n_checks++; if (int'(dut.drop) != 2) $display("FAIL j3_drop: got %0d want 2", dut.drop); else n_pass++;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL j3_cleared: got %b want 0", o_valid); else n_pass++;
        step();
        n_checks++; if (!(s_xfer && s_iaddr == 32'h200)) $display("FAIL j3_next_req: got xfer=%b addr=%h want 1/00000200", s_xfer, s_iaddr); else n_pass++;
        done = 1'b1;
      end else begin
        step();
      end
    end
    n_checks++; if (!done) $display("FAIL j3_reach: got no pc 0x108 want one within 30 cycles"); else n_pass++;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (s_valid) begin
        seen = 1'b1;
        n_checks++; if (s_pc !== 32'h200) $display("FAIL j3_pc: got %h want 00000200", s_pc); else n_pass++;
        n_checks++; if (s_inst !== mem_word(32'h200)) $display("FAIL j3_inst: got %h want %h", s_inst, mem_word(32'h200)); else n_pass++;
      end
    end
    n_checks++; if (!seen) $display("FAIL j3_timeout: got no o_valid want one within 20 cycles"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] tgts [2];
    logic        hit;
    tgts[0] = 32'h0000_0403;
    tgts[1] = 32'h0000_0600;
    grant_pct = 100; lat_min = 1; lat_max = 1;
    apply_reset();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) step();
    for (int j = 0; j < 2; j++) begin
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
        if (o_valid && bus.o_ireq && mq.size() != 0 && mq[0].ready <= cycle) begin
          i_jp_en = 1'b1; i_jp_addr = tgts[j];
          step();
          i_jp_en = 1'b0;
          hit = 1'b1;
          n_checks++; if (!(s_flush && s_xfer && s_resp)) $display("FAIL b2b_scenario%0d: got f=%b x=%b r=%b want 1/1/1", j, s_flush, s_xfer, s_resp); else n_pass++;
          n_checks++; if (int'(dut.drop) != mq.size()) $display("FAIL b2b_drop%0d: got %0d want %0d", j, dut.drop, mq.size()); else n_pass++;
        end else begin
          step();
          if (s_cons) begin
            n_checks++; if (s_pc !== s_exp_pc) $display("FAIL b2b_pc: got %h want %h", s_pc, s_exp_pc); else n_pass++;
          end
        end
      end
      n_checks++; if (!hit) $display("FAIL b2b_timeout%0d: got no jump window want one", j); else n_pass++;
    end
    for (int c = 0; c < 12; c++) begin
      step();
      if (s_xfer) begin
        n_checks++; if (s_iaddr !== s_exp_req) $display("FAIL b2b_iaddr: got %h want %h", s_iaddr, s_exp_req); else n_pass++;
      end
      if (s_cons) begin
        n_checks++; if (s_pc !== s_exp_pc) $display("FAIL b2b_after_pc: got %h want %h", s_pc, s_exp_pc); else n_pass++;
        n_checks++; if (s_inst !== mem_word(s_exp_pc)) $display("FAIL b2b_after_inst: got %h want %h", s_inst, mem_word(s_exp_pc)); else n_pass++;
      end
    end
  endtask

  task automatic test_jump_stall();
    logic [31:0] want [4];
    logic [31:0] pc0;
    int          k = 0;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000; want[3] = 32'h0000_0004;
    grant_pct = 100; lat_min = 1; lat_max = 1;
    apply_reset();
    rst = 1'b0;
    for (int c = 0; c < 10 && !o_valid; c++) step();
    pc0 = o_pc;
    i_stall = 1'b1; i_jp_en = 1'b1; i_jp_addr = 32'hFFFF_FFF9;
    for (int c = 0; c < 3; c++) step();
    n_checks++; if (o_valid !== 1'b1) $display("FAIL js_valid: got %b want 1", o_valid); else n_pass++;
    n_checks++; if (o_pc !== pc0) $display("FAIL js_pc_held: got %h want %h", o_pc, pc0); else n_pass++;
    n_checks++; if (int'(dut.drop) != 0) $display("FAIL js_no_flush: got drop %0d want 0", dut.drop); else n_pass++;
    i_stall = 1'b0;
    step();
    i_jp_en = 1'b0;
    n_checks++; if (s_flush !== 1'b1) $display("FAIL js_flush: got %b want 1", s_flush); else n_pass++;
    for (int c = 0; c < 20 && k < 4; c++) begin
      step();
      if (s_cons) begin
        n_checks++; if (s_pc !== want[k]) $display("FAIL js_wrap_pc%0d: got %h want %h", k, s_pc, want[k]); else n_pass++;
        n_checks++; if (s_inst !== mem_word(want[k])) $display("FAIL js_wrap_inst%0d: got %h want %h", k, s_inst, mem_word(want[k])); else n_pass++;
        k++;
      end
    end
    n_checks++; if (k != 4) $display("FAIL js_timeout: got %0d pops want 4", k); else n_pass++;
  endtask

  task automatic test_random();
    logic pend = 1'b0;
    int   sum;
    grant_pct = 50; lat_min = 1; lat_max = 3;
    apply_reset();
    rst = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (n == 5000) begin
        apply_reset();
        pend = 1'b0;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", o_valid); else n_pass++;
        n_checks++; if (o_pc !== RPC) $display("FAIL mid_reset_pc: got %h want %h", o_pc, RPC); else n_pass++;
        n_checks++; if (o_inst !== 32'h0) $display("FAIL mid_reset_inst: got %h want 0", o_inst); else n_pass++;
        n_checks++; if (int'(dut.count) + int'(dut.outst) + int'(dut.drop) != 0) $display("FAIL mid_reset_ctrs: got %0d/%0d/%0d want 0/0/0", dut.count, dut.outst, dut.drop); else n_pass++;
        rst = 1'b0;
      end
      i_stall = ($urandom_range(3) == 0);
      if (!pend && o_valid && $urandom_range(19) == 0) begin
        pend = 1'b1;
        i_jp_addr = $urandom;
      end
      i_jp_en = pend;
      step();
      if (s_flush) pend = 1'b0;
      if (s_xfer) begin
        n_checks++; if (s_iaddr !== s_exp_req) $display("FAIL rnd_iaddr@%0d: got %h want %h", n, s_iaddr, s_exp_req); else n_pass++;
      end
      if (s_cons) begin
        n_checks++; if (s_pc !== s_exp_pc) $display("FAIL rnd_pc@%0d: got %h want %h", n, s_pc, s_exp_pc); else n_pass++;
        n_checks++; if (s_inst !== mem_word(s_exp_pc)) $display("FAIL rnd_inst@%0d: got %h want %h", n, s_inst, mem_word(s_exp_pc)); else n_pass++;
      end
      sum = int'(dut.count) + int'(dut.outst) + int'(dut.drop);
      n_checks++; if (sum > DEPTH) $display("FAIL rnd_credit@%0d: got %0d want <= %0d", n, sum, DEPTH); else n_pass++;
      n_checks++; if (int'(dut.outst) + int'(dut.drop) != mq.size()) $display("FAIL rnd_inflight@%0d: got %0d want %0d", n, int'(dut.outst) + int'(dut.drop), mq.size()); else n_pass++;
    end
    i_jp_en = 1'b0;
    i_stall = 1'b0;
  endtask

  initial begin
    i_stall      = 1'b0;
    i_jp_en      = 1'b0;
    i_jp_addr    = '0;
    bus.i_igrant = 1'b0;
    bus.i_ivalid = 1'b0;
    bus.i_idata  = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_stall_fill();
    test_jump_lat3();
    test_back_to_back();
    test_jump_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the core's single-cycle PC/fetch path.
- Decouples the core from instruction memory latency. It issues sequential fetch requests over a request/grant bus, accepts in-order responses of variable latency, and buffers them with their PCs in a DEPTH-entry prefetch queue.
- Presents one instruction per cycle to decode. A taken jump flushes the queue and silently drops responses that are still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, prefetch queue entries; power of two, 2..16. Also the cap on queued plus outstanding requests.
- XLEN, 32, address/instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_stall  in  1  core stall (external, vector busy or load wait); current instruction not consumed.
- i_jp_en  in  1  jump/branch taken by the instruction currently on o_inst.
- i_jp_addr  in  XLEN  jump target; bits [1:0] ignored (forced 0).
- o_ireq  out  1  fetch request valid.
- o_iaddr  out  XLEN  fetch address.
- i_igrant  in  1  memory accepts the request this cycle (transfer = o_ireq & i_igrant).
- i_ivalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- i_idata  in  XLEN  response instruction word.
- o_valid  out  1  o_inst/o_pc valid.
- o_inst  out  XLEN  instruction at queue head.
- o_pc  out  XLEN  PC of o_inst.

Behaviour:
- consume = o_valid & !i_stall. flush = consume & i_jp_en. A jump while stalled or while !o_valid is ignored; the core holds i_jp_en until consume.
- State:
  - f_pc: next fetch address.
  - r_pc: PC tagged onto the next accepted response.
  - queue: DEPTH x {pc, inst} with head/tail pointers and count (0..DEPTH).
  - outst: granted requests with no response yet (0..DEPTH).
  - drop: responses still to be discarded (0..DEPTH).
- Reset:
  - f_pc = r_pc = RESET_PC.
  - Queue empty; outst = drop = 0.
  - o_valid = 0; o_ireq = 0 in the reset cycle.
  - o_inst = 0, o_pc = RESET_PC.
- Reset mid-operation discards everything. Instruction memory must be reset on the same rst, so no stale responses follow.
- Request: o_ireq = !rst & (count + outst + drop < DEPTH). o_iaddr = f_pc. On transfer: f_pc += 4 (wraps modulo 2^XLEN) and outst += 1.
- Response: when i_ivalid:
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise: push {r_pc, i_idata}; r_pc += 4; outst -= 1.
- Output: o_valid = (count != 0). o_inst/o_pc are the queue head, combinational from the queue; there is no response-to-output bypass. Minimum latency is grant -> response -> o_valid on the next cycle.
- On consume, the head is popped.
- Simultaneous push and pop in one cycle: count unchanged. Push into a full queue cannot occur, because the credit rule guarantees space.
- On flush, in the same clock edge:
  - Queue cleared (count = 0).
  - f_pc = r_pc = {i_jp_addr[XLEN-1:2], 2'b00}.
  - drop = drop + outst, plus 1 if a transfer occurs this cycle, minus 1 if i_ivalid arrives this cycle with drop = 0. In that case the arriving response is discarded.
  - outst = 0.
  - o_ireq is still evaluated this cycle with pre-flush f_pc. A request granted in the flush cycle is counted into drop.
- The first post-flush request issues in the cycle after the flush, subject to the credit rule (drop consumes credit).
- Counters never under- or overflow. The bench asserts 0 <= count + outst + drop <= DEPTH every cycle.
- Credit flow sustains one instruction per cycle, provided round-trip latency < DEPTH.

Test Plan:
- Reset, RESET_PC = 0x100, memory with 1-cycle latency, always granting, no stall -> o_iaddr sequence 0x100, 0x104, ...; first o_valid with o_pc = 0x100 on the 3rd cycle after rst falls; thereafter one instruction per cycle.
- DEPTH = 4, i_stall held high, memory responds -> o_ireq drops after 4 transfers; count = 4; o_pc stays 0x100; deassert i_stall -> 4 consecutive pops, then requests resume.
- Memory latency 3, i_jp_en with i_jp_addr = 0x203 on a consume at o_pc = 0x108 with 2 requests outstanding -> next o_iaddr = 0x200; the 2 stale responses are dropped; next o_valid shows o_pc = 0x200 with the memory word at 0x200.
- Jump in the same cycle as an arriving response and a granted request -> both discarded; drop accounting correct; no stale o_pc ever appears.
- i_jp_en asserted while i_stall = 1 -> no flush; flush occurs on the first cycle with i_stall = 0.
- Random grant (50%) and latency 1..3 with random jumps and stalls over 10k cycles -> o_pc sequence matches a reference PC model; the counter-sum invariant holds; rst asserted mid-stream returns all state to reset values the next cycle.
